// File: rtl/reg_file_param.sv
// Parametrised integer register file with a hardware clear sequencer.
// Latency: reads are combinational (0 cycles), with same-cycle write-to-read bypass.
//   Writes are visible through storage from the cycle after the clock edge.
// Backpressure: ready_o is low while clearing, and the hazard unit must hold
//   issue until it rises; writes, flushes and reads are ignored/zeroed meanwhile.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i  - clock, reset, re-clear request
//   we_i, rd_i, rf_wd_i                         - write port
//   rs1_i/rs1_d_o, rs2_i/rs2_d_o                - asynchronous read ports
//   ready_o                                     - registered, high when usable
module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] rf_wd_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [XLEN-1:0] rs1_d_o,
  output logic [XLEN-1:0] rs2_d_o,
  output logic            ready_o
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam bit            ZR       = (ZERO_REG != 0);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            wr_ok;

  // A write that really lands in READY; also the bypass qualifier, so a
  // dropped write (flush or hardwired x0) is never forwarded either.
  assign wr_ok = we_i && !flush_i && !(ZR && (rd_i == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_wa    = rd_i;
    mem_wd    = rf_wd_i;
    case (state_q)
      S_CLEAR: begin
        // One entry per cycle; the index wraps to 0 naturally on the last one
        // because NREGS == 2**AW.
        mem_we    = 1'b1;
        mem_wa    = clr_idx_q;
        mem_wd    = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (flush_i) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end else if (wr_ok) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
    endcase
    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it. The
  // rst_i term stops the sequencer writing while reset is still held.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (state_q != S_READY) begin
      val = '0;
    end else if (ZR && (addr == '0)) begin
      val = '0;
    end else if (wr_ok && (rd_i == addr)) begin
      val = rf_wd_i;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  assign rs1_d_o = read_port(rs1_i);
  assign rs2_d_o = read_port(rs2_i);
  assign ready_o = ready_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a default instance (32x32, x0 hardwired)
// and a small instance (8x16, x0 ordinary). Stimulus pushes expected values;
// a negedge monitor pops and compares them against the live outputs.
module tb_reg_file_param;

  localparam int K_RS1  = 0;
  localparam int K_RS2  = 1;
  localparam int K_RDY  = 2;
  localparam int K1_RS1 = 3;
  localparam int K1_RS2 = 4;
  localparam int K1_RDY = 5;

  typedef struct {
    int          id;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, we;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] wd;
  logic [31:0] rs1_d, rs2_d;
  logic        rdy;

  logic        flush1, we1;
  logic [2:0]  rd1, rs1_1, rs2_1;
  logic [15:0] wd1;
  logic [15:0] rs1_d1, rs2_d1;
  logic        rdy1;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   next_id = 0;

  always #5 clk = ~clk;

  reg_file_param dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .we_i(we), .rd_i(rd),
    .rf_wd_i(wd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_d_o(rs1_d), .rs2_d_o(rs2_d), .ready_o(rdy)
  );

  reg_file_param #(.XLEN(16), .NREGS(8), .AW(3), .ZERO_REG(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .we_i(we1), .rd_i(rd1),
    .rf_wd_i(wd1), .rs1_i(rs1_1), .rs2_i(rs2_1),
    .rs1_d_o(rs1_d1), .rs2_d_o(rs2_d1), .ready_o(rdy1)
  );

  function automatic string kname(input int k);
    case (k)
      K_RS1:   return "rs1_d_o";
      K_RS2:   return "rs2_d_o";
      K_RDY:   return "ready_o";
      K1_RS1:  return "small.rs1_d_o";
      K1_RS2:  return "small.rs2_d_o";
      default: return "small.ready_o";
    endcase
  endfunction

  // Monitor: outputs are combinational/registered and stable mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = sb_q.pop_front();
      case (e.kind)
        K_RS1:   got = rs1_d;
        K_RS2:   got = rs2_d;
        K_RDY:   got = {31'd0, rdy};
        K1_RS1:  got = {16'd0, rs1_d1};
        K1_RS2:  got = {16'd0, rs2_d1};
        default: got = {31'd0, rdy1};
      endcase
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL chk%0d %s: got 0x%08h expected 0x%08h at %0t",
                 e.id, kname(e.kind), got, e.val, $time);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] val);
    exp_t e;
    e.id   = next_id;
    e.kind = kind;
    e.val  = val;
    next_id++;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
    flush1 = 1'b0; we1 = 1'b0; rd1 = '0; wd1 = '0; rs1_1 = '0; rs2_1 = '0;
  endtask

  // Count edges after reset release: big file ready after edge 32, small after 8.
  task automatic check_ready_ramp();
    for (int e = 1; e <= 32; e++) begin
      step();
      expect_val(K_RDY, (e >= 32) ? 32'd1 : 32'd0);
      expect_val(K1_RDY, (e >= 8) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      expect_val(K_RS1, 32'd0);
      expect_val(K_RS2, 32'd0);
      step();
    end
    rs1 = '0; rs2 = '0;
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; wd = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    idle_inputs();

    // Asynchronous reset pulse mid-cycle; outputs must go idle while held.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_val(K_RDY, 32'd0);
    expect_val(K1_RDY, 32'd0);
    expect_val(K_RS1, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    check_ready_ramp();
    check_all_zero();

    // Write then read back through storage; x0 writes are dropped.
    write0(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5;
    expect_val(K_RS1, 32'hDEADBEEF);
    step();
    we = 1'b1; rd = 5'd0; wd = 32'h12345678; rs2 = 5'd0;
    expect_val(K_RS2, 32'd0);
    step();
    we = 1'b0;
    expect_val(K_RS2, 32'd0);
    step();

    // Same-cycle bypass on both ports, then the same write aimed at x0.
    write0(5'd7, 32'h1);
    we = 1'b1; rd = 5'd7; wd = 32'hCAFEF00D; rs1 = 5'd7; rs2 = 5'd7;
    expect_val(K_RS1, 32'hCAFEF00D);
    expect_val(K_RS2, 32'hCAFEF00D);
    step();
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    expect_val(K_RS1, 32'd0);
    expect_val(K_RS2, 32'd0);
    step();
    we = 1'b0;

    // Flush with a concurrent write: no bypass, write dropped, re-clear.
    write0(5'd3, 32'h33);
    write0(5'd9, 32'h99);
    flush = 1'b1; we = 1'b1; rd = 5'd3; wd = 32'hAA; rs1 = 5'd3; rs2 = 5'd9;
    expect_val(K_RS1, 32'h33);
    expect_val(K_RS2, 32'h99);
    expect_val(K_RDY, 32'd1);
    step();
    flush = 1'b0; rd = 5'd9; wd = 32'h55; rs1 = 5'd9; rs2 = 5'd3;
    for (int c = 1; c <= 32; c++) begin
      expect_val(K_RDY, 32'd0);
      expect_val(K_RS1, 32'd0);
      if (c == 5) expect_val(K_RS2, 32'd0);
      step();
    end
    we = 1'b0; rs1 = 5'd3; rs2 = 5'd9;
    expect_val(K_RDY, 32'd1);
    expect_val(K_RS1, 32'd0);
    expect_val(K_RS2, 32'd0);
    step();

    // Reset in the middle of a clear restarts the whole sequence.
    write0(5'd20, 32'h2020);
    write0(5'd31, 32'h3131);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 1; c < 10; c++) step();
    @(posedge clk);
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    check_ready_ramp();
    check_all_zero();

    // Small instance: x0 is ordinary storage and bypasses normally.
    we1 = 1'b1; rd1 = 3'd0; wd1 = 16'hBEEF; rs1_1 = 3'd0;
    expect_val(K1_RS1, 32'h0000BEEF);
    step();
    we1 = 1'b0; rs2_1 = 3'd0;
    expect_val(K1_RS1, 32'h0000BEEF);
    expect_val(K1_RS2, 32'h0000BEEF);
    step();
    step();

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor of the core integer register file: configurable data width, depth and x0-hardwiring.
- Two asynchronous read ports with same-cycle write-to-read bypass.
- Hardware clear sequencer zeroes every entry after reset, or on a flush request, and reports readiness to the pipeline.
- Sits in the decode stage; the hazard unit stalls issue while ready_o is low.

Parameters:
- XLEN, 32: data width of every entry, write data and read data.
- NREGS, 32: number of entries; power of two, at least 2.
- AW, 5: address width; must equal log2(NREGS).
- ZERO_REG, 1: 1 = entry 0 is hardwired to zero (writes dropped, reads and bypass return 0); 0 = entry 0 is an ordinary register.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous request to re-clear all entries.
- we_i  in  1  write enable.
- rd_i  in  AW  write address.
- rf_wd_i  in  XLEN  write data.
- rs1_i  in  AW  read port 1 address.
- rs2_i  in  AW  read port 2 address.
- rs1_d_o  out  XLEN  read port 1 data, combinational.
- rs2_d_o  out  XLEN  read port 2 data, combinational.
- ready_o  out  1  registered; high when the file is usable.

Behaviour:
- State machine
  - Two states: CLEAR and READY, plus an AW-bit clear index clr_idx.
  - ready_o is 1 only in READY.
- Reset
  - rst_i high asynchronously sets state=CLEAR, clr_idx=0, ready_o=0.
  - Storage contents are not reset directly.
  - Reset asserted mid-clear, or at any other time, restarts the sequence from index 0.
- CLEAR
  - Each rising edge with rst_i low writes 0 to entry clr_idx, then increments clr_idx.
  - The edge that writes entry NREGS-1 moves to READY; clr_idx wraps to 0.
  - ready_o therefore rises on the NREGS-th rising edge after reset release: edge 32 with defaults.
  - In CLEAR: we_i is ignored, flush_i is ignored, and both read outputs are forced to 0.
- READY
  - we_i=1 writes rf_wd_i to entry rd_i at the rising edge.
  - With ZERO_REG=1 and rd_i=0, the write is dropped.
- Flush
  - flush_i=1 in READY drops any write requested in the same cycle.
  - At that edge: state→CLEAR, clr_idx=0, ready_o=0.
  - Full re-clear takes NREGS cycles, as after reset.
- Reads (READY)
  - rsN_d_o = 0 if ZERO_REG=1 and rsN_i=0.
  - Otherwise rsN_d_o = rf_wd_i if the bypass condition holds.
  - Otherwise rsN_d_o = stored entry rsN_i.
  - Bypass condition: we_i=1, flush_i=0, rd_i=rsN_i, and rd_i≠0 (the rd_i≠0 term applies only when ZERO_REG=1).
  - Both ports bypass independently; rs1_i=rs2_i=rd_i bypasses on both.
- Read latency: 0 cycles (combinational). Write latency: visible through storage from the cycle after the edge, and through bypass in the same cycle.
- Widths
  - Address inputs are used as-is; no range checking beyond AW bits.
  - NREGS must equal 2^AW, so every address is valid.

Test Plan:
- Reset sequence: pulse rst_i asynchronously mid-cycle, release, sample ready_o each edge.
  - ready_o=0 for edges 1..31; ready_o=1 after edge 32.
  - Read all 32 entries → all 0.
- Write/read: write 0xDEADBEEF to entry 5, then read rs1_i=5 next cycle → 0xDEADBEEF.
  - Write 0x12345678 to entry 0 → rs2_i=0 reads 0 (ZERO_REG=1).
- Bypass: entry 7 holds 0x1; in one cycle drive we_i=1, rd_i=7, rf_wd_i=0xCAFEF00D, rs1_i=rs2_i=7.
  - Both outputs read 0xCAFEF00D in that cycle.
  - Same stimulus with rd_i=0 → both outputs 0.
- Flush with concurrent write: entries hold nonzero values; assert flush_i with we_i=1, rd_i=3, rf_wd_i=0xAA.
  - ready_o falls next cycle; reads return 0 during CLEAR.
  - we_i during CLEAR has no effect.
  - After 32 cycles: ready_o=1 and entry 3 reads 0.
- Reset mid-clear: assert rst_i at clear edge 10, release.
  - ready_o stays 0 for a full 32 further edges, then all entries read 0.
- ZERO_REG=0, NREGS=8, AW=3, XLEN=16: write 0xBEEF to entry 0 → reads back 0xBEEF.
  - ready_o rises on the 8th edge after reset release.
